// File: rtl/ram_rr_arb_pkg.sv
// Shared types and helpers for the round-robin RAM port arbiter.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: arbiter state encoding, requester-count bounds, one-hot to index encoder.

package ram_arb_pkg;

   // Arbiter FSM encoding; values are visible on debug probes, so keep them fixed.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      ERR   = 2'd2
   } arb_state_t;

   // Supported requester count range.
   localparam int N_MIN = 2;
   localparam int N_MAX = 8;

   // Index width able to address any requester up to N_MAX.
   localparam int IW = $clog2(N_MAX);

   // One-hot to binary index. OR-reduction form: correct for one-hot input,
   // returns 0 for an all-zero vector.
   function automatic logic [IW-1:0] oh2idx(input logic [N_MAX-1:0] oh);
      logic [IW-1:0] idx;
      idx = '0;
      for (int i = 0; i < N_MAX; i++) begin
         if (oh[i]) begin
            idx = idx | IW'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/ram_rr_arb_rr_pick.sv
// Rotating-priority picker: first requester at or after ptr (mod N) wins.
// Latency: purely combinational.
// Backpressure: none; caller decides when to register the result.
// Ports: req (per-requester request), ptr (highest-priority index),
//        gnt (one-hot winner, zero when no request), vld (any request present).

module rr_pick #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic          vld
);

   // Scan from the lowest priority (ptr+N-1) up to the highest (ptr), so the
   // last hit written is the winner. Avoids a separate found flag.
   always_comb begin
      gnt = '0;
      for (int off = N - 1; off >= 0; off--) begin
         int idx;
         idx = (int'(ptr) + off) % N;
         if (req[idx]) begin
            gnt = N'(1) << idx;
         end
      end
   end

   assign vld = |req;

endmodule

// File: rtl/ram_rr_arb.sv
// N-port round-robin arbiter sharing one Wishbone-classic slave port.
// Latency: grant registered 1 cycle after request; ack/rdata pass through combinationally.
// Backpressure: losers hold m_cyc until served; granted slot waits on x_ack, abort or watchdog.
// Ports: wb_clk/wb_rst_n; m_* packed per-requester master side (slot i at [W*i +: W]);
//        x_* shared slave side; grant is the one-hot owner for status/debug.

module ram_rr_arb
   import ram_arb_pkg::*;
#(
   parameter int N       = 4,   // requesters, N_MIN..N_MAX
   parameter int AW      = 32,
   parameter int TIMEOUT = 15   // GRANT cycles without x_ack before error; 0 disables
) (
   input  logic            wb_clk,
   input  logic            wb_rst_n,

   input  logic [N-1:0]    m_cyc,
   input  logic [N-1:0]    m_we,
   input  logic [4*N-1:0]  m_sel,
   input  logic [AW*N-1:0] m_adr,
   input  logic [32*N-1:0] m_dat,
   output logic [N-1:0]    m_ack,
   output logic [N-1:0]    m_err,
   output logic [32*N-1:0] m_rdt,

   output logic            x_cyc,
   output logic            x_we,
   output logic [3:0]      x_sel,
   output logic [AW-1:0]   x_adr,
   output logic [31:0]     x_dat,
   input  logic            x_ack,
   input  logic [31:0]     x_rdt,

   output logic [N-1:0]    grant
);

   localparam int PW = $clog2(N);
   // Watchdog counter only needs to reach TIMEOUT-1; keep one bit when disabled.
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

   arb_state_t     state, state_nxt;
   logic [N-1:0]   grant_nxt;
   logic [PW-1:0]  ptr, ptr_nxt;
   logic [CW-1:0]  count, count_nxt;

   logic [N-1:0]   pick_gnt;
   logic           pick_vld;
   logic [IW-1:0]  g_idx;
   logic [PW-1:0]  ptr_adv;
   logic           in_grant;
   logic           cyc_g;
   logic [N-1:0]   route;

   rr_pick #(
      .N  (N),
      .PW (PW)
   ) u_pick (
      .req (m_cyc),
      .ptr (ptr),
      .gnt (pick_gnt),
      .vld (pick_vld)
   );

   assign g_idx    = oh2idx(N_MAX'(grant));
   // Whoever just finished (ack, abort or error) drops to lowest priority.
   assign ptr_adv  = PW'((int'(g_idx) + 1) % N);
   assign in_grant = (state == GRANT);
   assign cyc_g    = |(m_cyc & grant);
   // Only the owner's slot is routed, and only while the bus is really owned.
   assign route    = grant & {N{in_grant}};

   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state <= IDLE;
         grant <= '0;
         ptr   <= '0;
         count <= '0;
      end else begin
         state <= state_nxt;
         grant <= grant_nxt;
         ptr   <= ptr_nxt;
         count <= count_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      ptr_nxt   = ptr;
      count_nxt = count;
      case (state)
         IDLE: begin
            if (pick_vld) begin
               state_nxt = GRANT;
               grant_nxt = pick_gnt;
               count_nxt = '0;
            end
         end
         GRANT: begin
            // x_ack is checked first so a completion on the last watchdog
            // cycle still counts as a normal transfer.
            if (x_ack || !cyc_g) begin
               state_nxt = IDLE;
               grant_nxt = '0;
               ptr_nxt   = ptr_adv;
            end else if ((TIMEOUT > 0) && (count == CNT_LAST)) begin
               state_nxt = ERR;
            end else begin
               count_nxt = count + CW'(1);
            end
         end
         ERR: begin
            state_nxt = IDLE;
            grant_nxt = '0;
            ptr_nxt   = ptr_adv;
         end
         default: begin
            state_nxt = IDLE;
            grant_nxt = '0;
         end
      endcase
   end

   // AND-OR muxes: grant is one-hot, so OR-ing masked slots selects the owner.
   always_comb begin
      x_cyc = 1'b0;
      x_we  = 1'b0;
      x_sel = '0;
      x_adr = '0;
      x_dat = '0;
      m_rdt = '0;
      for (int i = 0; i < N; i++) begin
         x_cyc = x_cyc | (route[i] & m_cyc[i]);
         x_we  = x_we  | (route[i] & m_we[i]);
         x_sel = x_sel | ({4{route[i]}}  & m_sel[4*i +: 4]);
         x_adr = x_adr | ({AW{route[i]}} & m_adr[AW*i +: AW]);
         x_dat = x_dat | ({32{route[i]}} & m_dat[32*i +: 32]);
         m_rdt[32*i +: 32] = {32{route[i]}} & x_rdt;
      end
   end

   assign m_ack = route & {N{x_ack}};
   assign m_err = grant & {N{state == ERR}};

endmodule

// File: tb/tb_ram_rr_arb.sv
// Randomized bench for ram_rr_arb against a transaction-level arbitration model.
// Latency: n/a.
// Backpressure: bench masters hold requests until acked, errored or aborted.

module tb_ram_rr_arb;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int TO = 15;

   typedef struct {
      bit          we;
      int          widx;
      logic [31:0] dat;
      logic [3:0]  sel;
   } txn_t;

   logic            wb_clk;
   logic            wb_rst_n;
   logic [N-1:0]    m_cyc;
   logic [N-1:0]    m_we;
   logic [4*N-1:0]  m_sel;
   logic [AW*N-1:0] m_adr;
   logic [32*N-1:0] m_dat;
   logic [N-1:0]    m_ack;
   logic [N-1:0]    m_err;
   logic [32*N-1:0] m_rdt;
   logic            x_cyc;
   logic            x_we;
   logic [3:0]      x_sel;
   logic [AW-1:0]   x_adr;
   logic [31:0]     x_dat;
   logic            x_ack;
   logic [31:0]     x_rdt;
   logic [N-1:0]    grant;

   // Bench master registers.
   logic [N-1:0]    cyc_r, we_r, fin;
   logic [3:0]      sel_r [N];
   logic [AW-1:0]   adr_r [N];
   logic [31:0]     dat_r [N];
   txn_t            sq [N][$];

   // Stimulus knobs.
   int req_pct [N];
   int ack_pct;
   int abort_pct;

   // Reference model: who owns the bus, how long, and the rotation point.
   int own, age, ptr;
   bit in_err;
   logic [31:0] refmem  [64];
   logic [31:0] slvmem  [64];
   int waits [N];
   logic [N-1:0] prev_g;

   int n_tests, n_fail;

   ram_rr_arb #(.N(N), .AW(AW), .TIMEOUT(TO)) dut (
      .wb_clk  (wb_clk),
      .wb_rst_n(wb_rst_n),
      .m_cyc   (m_cyc),
      .m_we    (m_we),
      .m_sel   (m_sel),
      .m_adr   (m_adr),
      .m_dat   (m_dat),
      .m_ack   (m_ack),
      .m_err   (m_err),
      .m_rdt   (m_rdt),
      .x_cyc   (x_cyc),
      .x_we    (x_we),
      .x_sel   (x_sel),
      .x_adr   (x_adr),
      .x_dat   (x_dat),
      .x_ack   (x_ack),
      .x_rdt   (x_rdt),
      .grant   (grant)
   );

   assign m_cyc = cyc_r;
   assign m_we  = we_r;
   for (genvar i = 0; i < N; i++) begin : g_drv
      assign m_sel[4*i +: 4]   = sel_r[i];
      assign m_adr[AW*i +: AW] = adr_r[i];
      assign m_dat[32*i +: 32] = dat_r[i];
   end

   initial wb_clk = 1'b0;
   always #5 wb_clk = ~wb_clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   function automatic txn_t rand_txn();
      txn_t t;
      t.we   = 1'($urandom_range(1));
      t.widx = int'($urandom_range(63));
      t.dat  = $urandom;
      t.sel  = (($urandom_range(3)) == 0) ? 4'($urandom_range(15)) : 4'hF;
      return t;
   endfunction

   task automatic load(input int i, input txn_t t);
      cyc_r[i] = 1'b1;
      we_r[i]  = t.we;
      adr_r[i] = AW'(t.widx * 4);
      dat_r[i] = t.dat;
      sel_r[i] = t.sel;
      waits[i] = 0;
   endtask

   // Arbitration rules applied at each clock edge to the inputs seen there.
   task automatic model_edge();
      if (own >= 0) begin
         if (in_err || x_ack || !cyc_r[own]) begin
            ptr    = (own + 1) % N;
            own    = -1;
            in_err = 1'b0;
         end else begin
            age++;
            if (TO > 0 && age == TO) in_err = 1'b1;
         end
      end else if (cyc_r != '0) begin
         for (int k = N - 1; k >= 0; k--) if (cyc_r[(ptr + k) % N]) own = (ptr + k) % N;
         age = 0;
      end
   endtask

   // Fairness measured on the DUT's own grant: transactions finished while a
   // requester was waiting.
   task automatic track_fair();
      if (prev_g != '0 && grant == '0) begin
         for (int j = 0; j < N; j++) if (cyc_r[j] && !prev_g[j]) waits[j]++;
      end
      if (prev_g == '0 && grant != '0) begin
         for (int j = 0; j < N; j++) begin
            if (grant[j]) begin
               chk("fair_wait", 128'(waits[j] > N - 1), 128'(0));
               waits[j] = 0;
            end
         end
      end
      prev_g = grant;
   endtask

   task automatic drive_masters();
      txn_t t;
      for (int i = 0; i < N; i++) begin
         if (fin[i]) begin
            cyc_r[i] = 1'b0;
            fin[i]   = 1'b0;
         end
         if (!cyc_r[i]) begin
            if (sq[i].size() > 0) begin
               t = sq[i].pop_front();
               load(i, t);
            end else if (int'($urandom_range(99)) < req_pct[i]) begin
               t = rand_txn();
               load(i, t);
            end
         end else if (own == i && !in_err && int'($urandom_range(99)) < abort_pct) begin
            cyc_r[i] = 1'b0;
         end
      end
   endtask

   task automatic slave();
      x_ack = x_cyc && (int'($urandom_range(99)) < ack_pct);
      if (x_ack) begin
         x_rdt = slvmem[x_adr[7:2]];
         if (x_we) slvmem[x_adr[7:2]] = merge(slvmem[x_adr[7:2]], x_dat, x_sel);
      end else begin
         x_rdt = $urandom;
      end
   endtask

   task automatic step();
      logic [N-1:0]    exp_g, exp_ack, exp_err;
      logic [32*N-1:0] exp_rdt;
      bit              busy;
      @(posedge wb_clk);
      model_edge();
      #1;
      exp_g = (own >= 0) ? (N'(1) << own) : '0;
      chk("grant", 128'(grant), 128'(exp_g));
      track_fair();
      drive_masters();
      #1;
      slave();
      #1;
      busy    = (own >= 0) && !in_err;
      exp_ack = (busy && x_ack) ? (N'(1) << own) : '0;
      exp_err = (own >= 0 && in_err) ? (N'(1) << own) : '0;
      exp_rdt = '0;
      if (busy) exp_rdt[32*own +: 32] = x_rdt;
      chk("x_cyc", 128'(x_cyc), 128'(busy ? cyc_r[own] : 1'b0));
      chk("x_we",  128'(x_we),  128'(busy ? we_r[own]  : 1'b0));
      chk("x_sel", 128'(x_sel), 128'(busy ? sel_r[own] : 4'h0));
      chk("x_adr", 128'(x_adr), 128'(busy ? adr_r[own] : '0));
      chk("x_dat", 128'(x_dat), 128'(busy ? dat_r[own] : 32'h0));
      chk("m_ack", 128'(m_ack), 128'(exp_ack));
      chk("m_err", 128'(m_err), 128'(exp_err));
      chk("m_rdt", 128'(m_rdt), 128'(exp_rdt));
      if (busy && x_ack) begin
         if (we_r[own]) refmem[adr_r[own][7:2]] = merge(refmem[adr_r[own][7:2]], dat_r[own], sel_r[own]);
         else chk("rdata", 128'(m_rdt[32*own +: 32]), 128'(refmem[adr_r[own][7:2]]));
      end
      for (int i = 0; i < N; i++) fin[i] = m_ack[i] | m_err[i];
   endtask

   function automatic bit queued();
      bit q;
      q = 1'b0;
      for (int i = 0; i < N; i++) if (sq[i].size() > 0) q = 1'b1;
      return q;
   endfunction

   task automatic set_req(input int pct);
      for (int i = 0; i < N; i++) req_pct[i] = pct;
   endtask

   task automatic run(input int cycles);
      for (int c = 0; c < cycles; c++) step();
   endtask

   task automatic drain(input int max_cyc);
      int c;
      c = 0;
      set_req(0);
      abort_pct = 0;
      while ((cyc_r != '0 || queued()) && c < max_cyc) begin
         step();
         c++;
      end
      chk("drain", 128'(cyc_r), 128'(0));
   endtask

   initial begin
      txn_t t;
      n_tests = 0;
      n_fail  = 0;
      own = -1; age = 0; ptr = 0; in_err = 1'b0;
      prev_g = '0;
      cyc_r = '0; we_r = '0; fin = '0;
      for (int i = 0; i < N; i++) begin
         sel_r[i] = '0; adr_r[i] = '0; dat_r[i] = '0; waits[i] = 0; req_pct[i] = 0;
      end
      for (int w = 0; w < 64; w++) begin
         refmem[w] = '0;
         slvmem[w] = '0;
      end
      ack_pct = 50; abort_pct = 0;

      // Reset: all outputs must stay 0 even with every input active.
      wb_rst_n = 1'b0;
      cyc_r = '1; we_r = '1; x_ack = 1'b1; x_rdt = 32'hDEAD_BEEF;
      repeat (2) @(posedge wb_clk);
      #1;
      chk("rst_grant", 128'(grant), 128'(0));
      chk("rst_x_cyc", 128'(x_cyc), 128'(0));
      chk("rst_x_adr", 128'(x_adr), 128'(0));
      chk("rst_m_ack", 128'(m_ack), 128'(0));
      chk("rst_m_err", 128'(m_err), 128'(0));
      chk("rst_m_rdt", 128'(m_rdt), 128'(0));
      cyc_r = '0; we_r = '0; x_ack = 1'b0;
      @(negedge wb_clk);
      wb_rst_n = 1'b1;

      // Single write to 0x20 from requester 2, then read it back.
      sq[2].push_back('{1'b1, 8, 32'h1234_3456, 4'hF});
      sq[2].push_back('{1'b0, 8, 32'h0, 4'hF});
      drain(200);

      // All four requesters write on the same edge, then all read back.
      for (int i = 0; i < N; i++) begin
         sq[i].push_back('{1'b1, i, 32'hA5A5_0000 | 32'(i), 4'hF});
         sq[i].push_back('{1'b0, i, 32'h0, 4'hF});
      end
      drain(300);

      // General random traffic with aborts.
      set_req(30); ack_pct = 40; abort_pct = 5;
      run(1500);
      drain(300);

      // Requesters 0 and 3 hammer the bus; 3 must not starve.
      req_pct[0] = 100; req_pct[3] = 100; ack_pct = 60;
      run(300);
      drain(300);

      // Dead slave: every transaction times out.
      set_req(30); ack_pct = 0;
      run(400);
      drain(300);

      // Slow slave: mix of late acks (including on the last watchdog cycle) and timeouts.
      set_req(40); ack_pct = 7; abort_pct = 2;
      run(1500);
      ack_pct = 30;
      drain(400);

      // Asynchronous reset while a transfer is in progress.
      set_req(50); ack_pct = 0;
      for (int c = 0; c < 100 && !(own >= 0 && !in_err); c++) step();
      chk("rst_reach_grant", 128'(own >= 0 && !in_err), 128'(1));
      x_ack = 1'b1;
      wb_rst_n = 1'b0;
      #1;
      chk("arst_grant", 128'(grant), 128'(0));
      chk("arst_x_cyc", 128'(x_cyc), 128'(0));
      chk("arst_x_adr", 128'(x_adr), 128'(0));
      chk("arst_m_ack", 128'(m_ack), 128'(0));
      chk("arst_m_rdt", 128'(m_rdt), 128'(0));
      for (int i = 0; i < N; i++) begin
         if (!cyc_r[i]) begin
            t = rand_txn();
            load(i, t);
         end
         waits[i] = 0;
      end
      fin = '0;
      set_req(0);
      @(negedge wb_clk);
      x_ack = 1'b0;
      wb_rst_n = 1'b1;
      own = -1; age = 0; ptr = 0; in_err = 1'b0; prev_g = '0;
      ack_pct = 40;
      step();
      chk("arst_prio0", 128'(grant), 128'(1));
      set_req(30);
      run(200);
      drain(300);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_rr_arb.md
# ram_rr_arb

N-port round-robin arbiter sharing one Wishbone-classic memory port (sp_ram or any x-bus slave) between up to N requesters, with registered grant, abort handling and a bus timeout watchdog. Sits between CPU/DMA/peripheral masters and the shared RAM x-bus, and generalises two-port sharing to N ports with fairness and error recovery.

## Interface
- N, 4: number of requesters (2..8)
- AW, 32: address width
- TIMEOUT, 15: max cycles in GRANT without x_ack before error; 0 disables watchdog
- wb_clk  in  1  clock, all logic on rising edge
- wb_rst_n  in  1  asynchronous active-low reset
- m_cyc  in  N  per-requester cycle request
- m_we  in  N  per-requester write enable
- m_sel  in  4*N  byte selects, requester i at [4i+3:4i]
- m_adr  in  AW*N  addresses, requester i at [AW*i+AW-1:AW*i]
- m_dat  in  32*N  write data, packed as above
- m_ack  out  N  ack to granted requester only
- m_err  out  N  timeout error pulse to granted requester
- m_rdt  out  32*N  read data; zero for all non-granted slots
- x_cyc, x_we  out  1  shared bus strobes
- x_sel  out  4  shared byte selects
- x_adr  out  AW  shared address
- x_dat  out  32  shared write data
- x_ack  in  1  slave ack
- x_rdt  in  32  slave read data
- grant  out  N  one-hot current grant (debug/status)

## Operation
- States: IDLE, GRANT, ERR. Reset: IDLE, grant=0, ptr=0, count=0; all outputs 0.
- IDLE: if any m_cyc, winner = first requester with m_cyc set scanning ptr, ptr+1, ..., ptr+N-1 (mod N); grant<=onehot(winner), state<=GRANT, count<=0. No request: stay.
- GRANT: x_* driven from granted requester's m_* (x_cyc = m_cyc[g]); all x_* are 0 whenever state != GRANT.
- m_ack[g] = x_ack & state==GRANT; m_rdt slot g = x_rdt in GRANT, else 0; all other slots always 0.
- Exit on x_ack: state<=IDLE, grant<=0, ptr<=(g+1) mod N.
- Exit on abort (m_cyc[g]==0 in GRANT, no x_ack): state<=IDLE, grant<=0, ptr<=(g+1) mod N, no ack.
- Watchdog (TIMEOUT>0): count increments each GRANT cycle without x_ack; when count==TIMEOUT-1 and no x_ack: state<=ERR. x_ack on that same cycle wins (normal completion).
- ERR: one cycle; x_cyc=0; m_err[g]=1; m_ack=0; then IDLE, grant<=0, ptr<=(g+1) mod N.
- Requests from non-granted masters held pending indefinitely; arbiter never issues ack to them.

## Timing
- Grant latency: m_cyc rises before edge k -> grant/x_cyc valid after edge k (1 cycle, registered).
- Ack combinational from x_ack; master sees m_ack same cycle, drops m_cyc at the following edge.
- One IDLE dead cycle between back-to-back transactions; worst-case wait for a continuously requesting master: (N-1) transactions.
- Simultaneous requests: lowest index at or after ptr wins; after reset ptr=0 so requester 0 first.
- Timeout error asserts in cycle TIMEOUT+1 after grant (TIMEOUT GRANT cycles, then ERR).
- Reset mid-transaction: async clear to IDLE, all outputs 0 immediately, ptr=0; pending slave ack ignored.
- count width $clog2(TIMEOUT+1), saturating never needed (exit at TIMEOUT-1).

## Structure
- Package ram_arb_pkg: state enum (IDLE=2'd0, GRANT=2'd1, ERR=2'd2), N bound constant.
- Sub-module rr_pick: combinational rotate-priority picker (req[N], ptr -> onehot winner, valid); reused by future arbiters.
- Top holds FSM, ptr, count, and AND-OR muxes for x_* and m_rdt.

## Test plan
- Single write: m_cyc[2], adr 0x20, dat 0x12343456, sel 0xF -> x_cyc 1 cycle later with same fields; slave ack -> m_ack[2] only; x_* return to 0; readback 0x12343456.
- All four request same edge (writes 0x0/0x4/0x8/0xC) -> grant order 0,1,2,3, one IDLE cycle between each, all data correct.
- Requester 0 re-requests immediately after each ack while 3 waits -> grant sequence 0,3,0,...; 3 served within N-1 transactions.
- Abort: requester 1 drops m_cyc in GRANT before x_ack -> IDLE next cycle, no m_ack, ptr=2.
- Timeout: TIMEOUT=15, slave never acks -> m_err[g] pulses exactly one cycle after 15 GRANT cycles, x_cyc 0 in ERR, next requester granted afterward.
- Assert wb_rst_n low during GRANT -> grant, x_*, m_ack, m_rdt 0 immediately; after release, requester 0 has priority.
